// File: rtl/csa_resolver.sv
// Digit-serial carry-propagate resolver: turns a carry-save pair (s, c) into s + (c << 1).
// Optional saturation to 2^W-1 is enabled by defining CSA_RES_SAT_EN.
module csa_resolver #(
  parameter int W     = 13,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] s,
  input  logic [W-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:0] result,
  output logic         sat
);

  localparam int RW     = W + 2;
  localparam int NCHUNK = (RW + CHUNK - 1) / CHUNK;
  localparam int PADW   = NCHUNK * CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT           state_q, state_d;
  logic [PADW-1:0] opA_q, opA_d;
  logic [PADW-1:0] opB_q, opB_d;
  logic [PADW-1:0] acc_q, acc_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   count_q, count_d;
  logic [RW-1:0]   result_q, result_d;
  logic [CHUNK:0]  chunkSum;

  assign chunkSum = {1'b0, opA_q[CHUNK-1:0]} + {1'b0, opB_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};

`ifdef CSA_RES_SAT_EN
  logic sat_q, sat_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
`ifdef CSA_RES_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      result_q <= result_d;
`ifdef CSA_RES_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

  // Chunks enter the accumulator from the top, so after NCHUNK shifts the
  // first (least significant) chunk has landed at bit 0 and padding sits above RW.
  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    count_d  = count_q;
    result_d = result_q;
`ifdef CSA_RES_SAT_EN
    sat_d    = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d   = PADW'({2'b00, s});
          opB_d   = PADW'({1'b0, c, 1'b0});
          acc_d   = '0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opA_d   = opA_q >> CHUNK;
        opB_d   = opB_q >> CHUNK;
        carry_d = chunkSum[CHUNK];
        acc_d   = (acc_q >> CHUNK) | (PADW'(chunkSum[CHUNK-1:0]) << (PADW - CHUNK));
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = DONE;
`ifdef CSA_RES_SAT_EN
          if (|acc_d[RW-1:W]) begin
            result_d = RW'({W{1'b1}});
            sat_d    = 1'b1;
          end else begin
            result_d = acc_d[RW-1:0];
            sat_d    = 1'b0;
          end
`else
          result_d = acc_d[RW-1:0];
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
`ifdef CSA_RES_SAT_EN
  assign sat       = sat_q;
`else
  assign sat       = 1'b0;
`endif

endmodule
